// File: rtl/multi_port_bram_model.sv
// N-port byte-addressed block RAM model with a configurable read pipeline and write-collision counting.
// Optional macro MULTI_PORT_BRAM_COLLISION_FATAL_EN stops simulation on any byte-overlapping write collision.
module multi_port_bram_model #(
  parameter int SIZE         = 256,
  parameter int WIDTH        = 32,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  parameter int EN_RST_OUT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         en,
  input  logic [NUM_PORTS-1:0]         rst_out,
  input  logic [NUM_PORTS*32-1:0]      addr,
  input  logic [NUM_PORTS*WIDTH/8-1:0] we,
  input  logic [NUM_PORTS*WIDTH-1:0]   din,
  output logic [NUM_PORTS*WIDTH-1:0]   dout,
  output logic [NUM_PORTS-1:0]         dout_valid,
  output logic [31:0]                  collision_cnt
);
  localparam int NB = WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int AW = $clog2(SIZE);

  logic [WIDTH-1:0] mem [SIZE] = '{default: '0};

  logic [AW-1:0]    idx      [NUM_PORTS];
  logic [NB-1:0]    wmask    [NUM_PORTS];
  logic [WIDTH-1:0] wdata    [NUM_PORTS];
  logic [WIDTH-1:0] rdata    [NUM_PORTS];
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] out_clr;
  logic             collision;

  logic [WIDTH-1:0]        data_q  [NUM_PORTS][READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q [NUM_PORTS];

  // Address bits above the word index and below it (byte offset) are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  always_comb begin
    collision = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      idx[p]     = addr[p*32+BW +: AW];
      wmask[p]   = en[p] ? we[p*NB +: NB] : '0;
      wdata[p]   = din[p*WIDTH +: WIDTH];
      out_clr[p] = (EN_RST_OUT != 0) && en[p] && rst_out[p];
      accept[p]  = en[p] && !out_clr[p] && !rst;
      rdata[p]   = mem[idx[p]];
      // Write-first only merges this port's own bytes; other ports always see pre-write data.
      if (WRITE_MODE == 1) begin
        for (int b = 0; b < NB; b++) begin
          if (wmask[p][b]) rdata[p][b*8 +: 8] = wdata[p][b*8 +: 8];
        end
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if ((idx[p] == idx[q]) && ((wmask[p] & wmask[q]) != '0)) collision = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones, giving the highest-index port priority on shared bytes.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[p][b]) mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_cnt <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        valid_q[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) data_q[p][s] <= '0;
      end
    end else begin
      if (collision && (collision_cnt != '1)) collision_cnt <= collision_cnt + 32'd1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        valid_q[p][0] <= accept[p];
        if (accept[p]) data_q[p][0] <= rdata[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          valid_q[p][s] <= valid_q[p][s-1];
          if (valid_q[p][s-1]) data_q[p][s] <= data_q[p][s-1];
        end
        // Output-register reset only touches the last stage; earlier stages keep advancing.
        if (out_clr[p]) begin
          valid_q[p][READ_LATENCY-1] <= 1'b0;
          data_q[p][READ_LATENCY-1]  <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      dout[p*WIDTH +: WIDTH] = data_q[p][READ_LATENCY-1];
      dout_valid[p]          = valid_q[p][READ_LATENCY-1];
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (en[p] && $isunknown(addr[p*32+BW +: AW])) begin
          $error("multi_port_bram_model: unknown address on port %0d", p);
          $fatal(1, "multi_port_bram_model: stopping on unknown address");
        end
      end
`ifdef MULTI_PORT_BRAM_COLLISION_FATAL_EN
      if (collision) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          for (int q = p + 1; q < NUM_PORTS; q++) begin
            if ((idx[p] == idx[q]) && ((wmask[p] & wmask[q]) != '0))
              $error("multi_port_bram_model: write collision ports %0d and %0d word %0d", p, q, idx[p]);
          end
        end
        $fatal(1, "multi_port_bram_model: stopping on write collision");
      end
`else
      if (collision) begin
      end
`endif
    end
  end
endmodule

// File: doc/multi_port_bram_model.md
Name: multi_port_bram_model

Overview:
- Parametrised simulation model of a byte-addressed, N-port block RAM. It succeeds the two-port, single-cycle memory wrapper used in the OmpSs manager testbenches.
- Adds an arbitrary port count, configurable read pipeline latency, read-first/write-first selection, per-port read-valid tracking and write-collision detection/counting.
- Sits in test benches behind BRAM-style interfaces of the manager (command queues, spawn queues).

Parameters:
- SIZE, 256: number of words; power of two.
- WIDTH, 32: word width in bits; multiple of 8, power of two.
- NUM_PORTS, 2: number of read/write ports, 1..8.
- READ_LATENCY, 1: cycles from accepted read to data on dout, 1..4.
- WRITE_MODE, 0: same-port read-during-write. 0 = read-first (old data), 1 = write-first (new data).
- EN_RST_OUT, 1: 1 enables per-port rst_out clearing of the output stage.

Ports:
- clk, input, 1: single clock for all ports.
- rst, input, 1: synchronous active-high reset.
- en, input, NUM_PORTS: per-port enable.
- rst_out, input, NUM_PORTS: per-port output-register reset (BRAM RSTA/RSTB style).
- addr, input, NUM_PORTS*32: byte addresses, port p at [p*32+31:p*32].
- we, input, NUM_PORTS*WIDTH/8: byte write enables, port p at [p*WIDTH/8 +: WIDTH/8].
- din, input, NUM_PORTS*WIDTH: write data, port p at [p*WIDTH +: WIDTH].
- dout, output, NUM_PORTS*WIDTH: read data, port p at [p*WIDTH +: WIDTH].
- dout_valid, output, NUM_PORTS: high for exactly one cycle when dout of port p carries data of a read issued READ_LATENCY cycles earlier.
- collision_cnt, output, 32: number of cycles with a byte-overlapping write collision; saturates at 0xFFFFFFFF.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: dout=0, dout_valid=0, all pipeline stages=0, collision_cnt=0.
- Memory contents are zero at time 0 and are NOT cleared by rst.
- Word index = addr[$clog2(WIDTH/8)+$clog2(SIZE)-1 : $clog2(WIDTH/8)]. Upper bits and byte-offset bits are ignored, so addresses wrap modulo SIZE*WIDTH/8.
- Read accept: en[p]=1 at edge k, whether or not any we bit is set. Data appears on dout[p] at edge k+READ_LATENCY-1, so READ_LATENCY=1 behaves like the legacy wrapper (registered after one edge). dout_valid[p] is asserted for the same cycle.
- Pipeline: READ_LATENCY stages per port, advancing every clk regardless of en.
- dout holds its last value when no new read arrives; dout_valid drops to 0.
- rst_out[p] with en[p] at edge k (EN_RST_OUT=1): the read is not accepted, and the last stage plus dout_valid clear to 0 at edge k. In-flight stages behind it are unaffected.
- Writes: at each edge, for each port with en[p], bytes with we[p][b]=1 are written.
- Same-port read during write: WRITE_MODE=0 returns the pre-write word. WRITE_MODE=1 returns the pre-write word with the written bytes merged in.
- Cross-port read during write: a read of a word that another port writes at the same edge always returns pre-write data.
- Write collision: two or more enabled ports write the same word with at least one common byte enabled.
  - Each overlapping byte takes the data from the highest-index port.
  - Non-overlapping bytes from every port are all written.
  - collision_cnt increments by 1 per such cycle, regardless of how many ports collide.
- X checking: if rst=0 and en[p]=1 with any X/Z bit in the used addr bits, the model issues $error and then $fatal.
- rst during operation: pipelines flush at that edge and no read issued at that edge is accepted. Writes with en at that edge are still performed, matching BRAM behaviour where rst does not gate writes.

Optional Feature:
- Macro: MULTI_PORT_BRAM_COLLISION_FATAL_EN.
- Defined: any byte-overlapping write collision with rst=0 triggers $error naming the ports and word index, then $fatal. collision_cnt is still maintained until the stop.
- Undefined: collisions resolve by highest-index priority and are only counted; simulation continues.

Test Plan:
- NUM_PORTS=2, READ_LATENCY=1: port0 writes 0xDEADBEEF to byte address 0x10 (we=4'hF), then port1 reads 0x10 -> dout[1]=0xDEADBEEF one edge after the read, with dout_valid[1]=1 for one cycle.
- READ_LATENCY=3: port0 reads addresses 0x0, 0x4, 0x8 back-to-back (preloaded 1,2,3) -> dout[0] shows 1,2,3 on consecutive cycles starting 3 edges after the first read, with dout_valid high for 3 cycles.
- WRITE_MODE=1, word=0x11223344: port0 reads and writes 0xAABBCCDD with we=4'b0011 at the same edge -> dout=0x1122CCDD. Repeat with WRITE_MODE=0 -> dout=0x11223344.
- NUM_PORTS=3: ports 0 and 2 write word 5 at the same edge, we=4'hF, data 0x1 and 0x2 -> mem reads back 0x2 and collision_cnt=1. With disjoint we masks 4'h3 and 4'hC -> merged word, collision_cnt unchanged.
- Read in flight with READ_LATENCY=2, then rst pulsed for one cycle -> dout=0, dout_valid stays 0, memory contents intact on re-read.
- Wrap: SIZE=256, WIDTH=32, write to byte address 0x400 -> subsequent read of 0x0 returns that data. An X address with en=1 and rst=0 -> simulation ends with $fatal.
